clock_divider_bank: RTL and testbench

Parametrised bank of independent synchronous clock dividers. Each channel produces a divided square-wave output and a one-cycle period-start tick. Each channel's divisor can be changed at runtime without glitches; the new value takes effect at the next period boundary through a shadow register. The bank feeds the RAMDAC pixel, line and DAC-strobe timing from one master clock, with optional phase realignment of all channels.

---
 rtl/clock_divider_bank_if.sv | 24 ++
 rtl/clock_divider_bank.sv | 80 ++++++++
 tb/tb_clock_divider_bank.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/clock_divider_bank_if.sv
// Bus bundle for clock_divider_bank: shared divisor, per-channel load strobes,
// phase sync, and the divided-clock / tick / status outputs.
interface clock_divider_bank_if #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8
);
  logic [WIDTH-1:0]          div_in;
  logic [CHANNELS-1:0]       load;
  logic                      sync;
  logic [CHANNELS-1:0]       clkout;
  logic [CHANNELS-1:0]       tick;
  logic [CHANNELS-1:0]       pending;
  logic [CHANNELS*WIDTH-1:0] active_div;

  modport master (
    output div_in, load, sync,
    input  clkout, tick, pending, active_div
  );

  modport slave (
    input  div_in, load, sync,
    output clkout, tick, pending, active_div
  );
endinterface

// File: rtl/clock_divider_bank.sv
// Bank of independent glitch-free clock dividers with shadowed divisors.
// Define CLOCK_DIVIDER_BANK_SYNC_EN to let `sync` realign all channel phases.
module clock_divider_bank #(
  parameter int CHANNELS = 2,
  parameter int WIDTH    = 8
) (
  input  logic                 clkin,
  input  logic                 reset,
  clock_divider_bank_if.slave  bus
);

  logic sync_fire;

`ifdef CLOCK_DIVIDER_BANK_SYNC_EN
  assign sync_fire = bus.sync;
`else
  assign sync_fire = 1'b0 & bus.sync;
`endif

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, div_q, shadow_q;
    logic [WIDTH-1:0] cnt_d, div_d, shadow_d, half_d;
    logic             pend_q, pend_d;
    logic             clk_q, tick_q;
    logic             apply_now;

    // Shadow always tracks the most recent load, so applying it at a boundary
    // with nothing pending simply re-applies the current divisor.
    always_comb begin
      cnt_d     = cnt_q;
      div_d     = div_q;
      shadow_d  = shadow_q;
      pend_d    = pend_q;
      apply_now = (div_q == '0) || (cnt_q == div_q - WIDTH'(1)) || sync_fire;
      if (bus.load[n]) begin
        shadow_d = bus.div_in;
        if (apply_now) begin
          div_d  = bus.div_in;
          pend_d = 1'b0;
          cnt_d  = '0;
        end else begin
          pend_d = 1'b1;
          cnt_d  = cnt_q + WIDTH'(1);
        end
      end else if (apply_now) begin
        div_d  = shadow_q;
        pend_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
      half_d = (div_d >> 1) + {{(WIDTH-1){1'b0}}, div_d[0]};
    end

    // Outputs are computed from the next state so they describe the post-edge state.
    always_ff @(posedge clkin) begin
      if (reset) begin
        cnt_q    <= '0;
        div_q    <= '0;
        shadow_q <= '0;
        pend_q   <= 1'b0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        div_q    <= div_d;
        shadow_q <= shadow_d;
        pend_q   <= pend_d;
        clk_q    <= (div_d != '0) && (cnt_d < half_d);
        tick_q   <= (div_d != '0) && (cnt_d == '0);
      end
    end

    assign bus.clkout[n]                   = clk_q;
    assign bus.tick[n]                     = tick_q;
    assign bus.pending[n]                  = pend_q;
    assign bus.active_div[n*WIDTH +: WIDTH] = div_q;
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Directed self-checking bench for clock_divider_bank (2 channels, 8-bit).
// Sync expectations follow CLOCK_DIVIDER_BANK_SYNC_EN.
module tb_clock_divider_bank;
  logic clkin = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  clock_divider_bank_if #(.CHANNELS(2), .WIDTH(8)) bus ();

  clock_divider_bank #(.CHANNELS(2), .WIDTH(8)) dut (
    .clkin (clkin),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clkin = ~clkin;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clkin);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.load = 2'b00;
    bus.sync = 1'b0;
    step();
    reset = 1'b0;
  endtask

  logic [2:0] pat3_clk, pat3_tick;
  logic [5:0] pat6_clk;

  initial begin
    bus.div_in = '0;
    bus.load   = 2'b00;
    bus.sync   = 1'b0;
    pat3_clk   = 3'b011;   // bit i = expected value at period offset i
    pat3_tick  = 3'b001;
    pat6_clk   = 6'b000111;
    step();
    do_reset();

    chk("rst_clkout",  {30'd0, bus.clkout}, 32'd0);
    chk("rst_tick",    {30'd0, bus.tick}, 32'd0);
    chk("rst_pending", {30'd0, bus.pending}, 32'd0);
    chk("rst_active",  {16'd0, bus.active_div}, 32'd0);

    // Stopped channel 0, load 3: applies on the load edge.
    bus.div_in = 8'd3; bus.load = 2'b01;
    step();
    bus.load = 2'b00;
    chk("d3_active",  {24'd0, bus.active_div[7:0]}, 32'd3);
    chk("d3_pending", {31'd0, bus.pending[0]}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("d3_clk%0d", i),  {31'd0, bus.clkout[0]}, {31'd0, pat3_clk[i % 3]});
      chk($sformatf("d3_tick%0d", i), {31'd0, bus.tick[0]},   {31'd0, pat3_tick[i % 3]});
      step();
    end

    // D=4 at cnt=1, then load 2: pending for two cycles, then alternate.
    do_reset();
    bus.div_in = 8'd4; bus.load = 2'b01;
    step();
    bus.load = 2'b00;
    step();
    bus.div_in = 8'd2; bus.load = 2'b01;
    step();
    bus.load = 2'b00;
    chk("shd_pend_a",  {31'd0, bus.pending[0]}, 32'd1);
    chk("shd_clk_a",   {31'd0, bus.clkout[0]}, 32'd0);
    chk("shd_old_div", {24'd0, bus.active_div[7:0]}, 32'd4);
    step();
    chk("shd_pend_b",  {31'd0, bus.pending[0]}, 32'd1);
    chk("shd_clk_b",   {31'd0, bus.clkout[0]}, 32'd0);
    step();
    chk("shd_pend_c",  {31'd0, bus.pending[0]}, 32'd0);
    chk("shd_new_div", {24'd0, bus.active_div[7:0]}, 32'd2);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("d2_clk%0d", i),  {31'd0, bus.clkout[0]}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("d2_tick%0d", i), {31'd0, bus.tick[0]},   (i % 2 == 0) ? 32'd1 : 32'd0);
      step();
    end

    // Channel 1 divide-by-1, then load 0 stops it on the next edge.
    bus.div_in = 8'd1; bus.load = 2'b10;
    step();
    bus.load = 2'b00;
    chk("d1_active", {24'd0, bus.active_div[15:8]}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d1_clk%0d", i),  {31'd0, bus.clkout[1]}, 32'd1);
      chk($sformatf("d1_tick%0d", i), {31'd0, bus.tick[1]},   32'd1);
      step();
    end
    bus.div_in = 8'd0; bus.load = 2'b10;
    step();
    bus.load = 2'b00;
    chk("stop_clk",    {31'd0, bus.clkout[1]}, 32'd0);
    chk("stop_tick",   {31'd0, bus.tick[1]}, 32'd0);
    chk("stop_active", {24'd0, bus.active_div[15:8]}, 32'd0);
    step();
    chk("stop_clk2",   {31'd0, bus.clkout[1]}, 32'd0);

    // Load 6 exactly on the boundary cycle of a D=3 period.
    do_reset();
    bus.div_in = 8'd3; bus.load = 2'b01;
    step();
    bus.load = 2'b00;
    step();
    step();
    bus.div_in = 8'd6; bus.load = 2'b01;
    step();
    bus.load = 2'b00;
    chk("bnd_active", {24'd0, bus.active_div[7:0]}, 32'd6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("bnd_clk%0d", i),  {31'd0, bus.clkout[0]},  {31'd0, pat6_clk[i]});
      chk($sformatf("bnd_tick%0d", i), {31'd0, bus.tick[0]},    (i == 0) ? 32'd1 : 32'd0);
      chk($sformatf("bnd_pend%0d", i), {31'd0, bus.pending[0]}, 32'd0);
      step();
    end

    // Ch0 D=5 at cnt 4, ch1 D=3 at cnt 1, then a one-cycle sync.
    do_reset();
    bus.div_in = 8'd5; bus.load = 2'b01;
    step();
    step();
    step();
    bus.div_in = 8'd3; bus.load = 2'b10;
    step();
    bus.load = 2'b00;
    step();
    bus.sync = 1'b1;
    step();
    bus.sync = 1'b0;
`ifdef CLOCK_DIVIDER_BANK_SYNC_EN
    chk("sync_tick",   {30'd0, bus.tick},   32'd3);
    chk("sync_clk",    {30'd0, bus.clkout}, 32'd3);
    for (int i = 0; i < 5; i++) step();
    chk("sync_tick5",  {30'd0, bus.tick},   32'd1);
    for (int i = 0; i < 10; i++) step();
    chk("sync_tick15", {30'd0, bus.tick},   32'd3);
`else
    chk("nosync_tick", {30'd0, bus.tick},   32'd1);
    chk("nosync_clk",  {30'd0, bus.clkout}, 32'd1);
    step();
    chk("nosync_tick1", {30'd0, bus.tick},  32'd2);
`endif

    // Reset mid-period wins over coincident load and sync.
    step();
    reset = 1'b1; bus.div_in = 8'd7; bus.load = 2'b11; bus.sync = 1'b1;
    step();
    chk("rw_clkout",  {30'd0, bus.clkout}, 32'd0);
    chk("rw_tick",    {30'd0, bus.tick}, 32'd0);
    chk("rw_pending", {30'd0, bus.pending}, 32'd0);
    chk("rw_active",  {16'd0, bus.active_div}, 32'd0);
    reset = 1'b0; bus.load = 2'b00; bus.sync = 1'b0;
    step();
    chk("rw_hold_clk",    {30'd0, bus.clkout}, 32'd0);
    chk("rw_hold_active", {16'd0, bus.active_div}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
